// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared types and segment patterns for the 7-segment display monitor
package comp_pkg;

  typedef enum logic [3:0] {
    D0 = 4'h0, D1 = 4'h1, D2 = 4'h2, D3 = 4'h3, D4 = 4'h4,
    D5 = 4'h5, D6 = 4'h6, D7 = 4'h7, D8 = 4'h8, D9 = 4'h9,
    DASH = 4'hA, BLANK = 4'hB, INVALID = 4'hF
  } digitCode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } monState_e;

  // Bit order is {A,B,C,D,E,F,G}
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic oneLow(input logic [3:0] nSel);
    return ($countones(~nSel) == 1);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational segment pattern to digit code decoder
module seg7_decode
  import comp_pkg::*;
(
  input  logic [6:0] pattern,
  output digitCode_e code
);

  always_comb begin
    case (pattern)
      SEG_0:     code = D0;
      SEG_1:     code = D1;
      SEG_2:     code = D2;
      SEG_3:     code = D3;
      SEG_4:     code = D4;
      SEG_5:     code = D5;
      SEG_6:     code = D6;
      SEG_7:     code = D7;
      SEG_8:     code = D8;
      SEG_9:     code = D9;
      SEG_DASH:  code = DASH;
      SEG_BLANK: code = BLANK;
      default:   code = INVALID;
    endcase
  end

endmodule

// File: rtl/seg_display_monitor.sv
// rtl/seg_display_monitor.sv - samples a multiplexed 4-digit 7-segment drive and publishes decoded frames
module seg_display_monitor
  import comp_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int STALL_CYCLES  = 65535
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        SegA,
  input  logic        SegB,
  input  logic        SegC,
  input  logic        SegD,
  input  logic        SegE,
  input  logic        SegF,
  input  logic        SegG,
  input  logic        DP,
  input  logic [3:0]  nDigit,
  output logic [15:0] Digits,
  output logic [3:0]  DPs,
  output logic        FrameValid,
  output logic        FrameError,
  output logic        Stalled
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] STALL_MAX   = TW'(STALL_CYCLES);

  logic [6:0]  pattern;
  logic [7:0]  inputs;
  logic [7:0]  prevInputs;
  digitCode_e  code;
  monState_e   state;
  logic [SW-1:0] settleCnt;
  logic [TW-1:0] stallCnt;
  logic [3:0]  selLatched;
  logic [3:0]  mask;
  logic [15:0] slotCodes;
  logic [3:0]  slotDps;
  logic [1:0]  selIdx;
  logic        selValid;
  logic        stable;
  logic        capture;
  logic        anyInvalid;

  assign pattern  = {SegA, SegB, SegC, SegD, SegE, SegF, SegG};
  assign inputs   = {pattern, DP};
  assign selValid = oneLow(nDigit);
  assign stable   = (nDigit == selLatched) && (inputs == prevInputs);
  // Capture on the edge where the stable run would reach SETTLE_CYCLES
  assign capture  = (state == SETTLE) && stable && (settleCnt >= SETTLE_LAST);

  seg7_decode uDecode (
    .pattern(pattern),
    .code   (code)
  );

  always_comb begin
    selIdx = 2'd0;
    case (selLatched)
      4'b1110: selIdx = 2'd0;
      4'b1101: selIdx = 2'd1;
      4'b1011: selIdx = 2'd2;
      4'b0111: selIdx = 2'd3;
      default: selIdx = 2'd0;
    endcase
  end

  always_comb begin
    anyInvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (slotCodes[4*i +: 4] == INVALID) anyInvalid = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state      <= IDLE;
      settleCnt  <= '0;
      stallCnt   <= '0;
      selLatched <= 4'hF;
      prevInputs <= '0;
      mask       <= '0;
      slotCodes  <= '0;
      slotDps    <= '0;
      Digits     <= 16'hBBBB;
      DPs        <= '0;
      FrameValid <= 1'b0;
      FrameError <= 1'b0;
      Stalled    <= 1'b0;
    end else begin
      prevInputs <= inputs;
      FrameValid <= 1'b0;

      // A full mask publishes one cycle after the completing capture
      if (mask == 4'hF) begin
        Digits     <= slotCodes;
        DPs        <= slotDps;
        FrameError <= anyInvalid;
        FrameValid <= 1'b1;
        mask       <= '0;
        slotCodes  <= '0;
        slotDps    <= '0;
      end

      case (state)
        IDLE: begin
          if (selValid) begin
            state      <= SETTLE;
            settleCnt  <= SW'(1);
            selLatched <= nDigit;
          end
        end
        SETTLE: begin
          if (capture) begin
            state                        <= HOLD;
            settleCnt                    <= '0;
            slotCodes[{selIdx, 2'b00} +: 4] <= code;
            slotDps[selIdx]              <= DP;
            mask[selIdx]                 <= 1'b1;
          end else if (stable) begin
            settleCnt <= settleCnt + SW'(1);
          end else if (selValid) begin
            settleCnt  <= SW'(1);
            selLatched <= nDigit;
          end else begin
            state     <= IDLE;
            settleCnt <= '0;
          end
        end
        HOLD: begin
          if (nDigit != selLatched) begin
            if (selValid) begin
              state      <= SETTLE;
              settleCnt  <= SW'(1);
              selLatched <= nDigit;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      Stalled <= (stallCnt == STALL_MAX);
      if (capture)                  stallCnt <= '0;
      else if (stallCnt != STALL_MAX) stallCnt <= stallCnt + TW'(1);
    end
  end

endmodule
